memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares one main-memory port between the instruction cache and the data cache. Each cache raises a level request, and the block grants one request at a time. It drives the memory's READ/WRITE/ADDRESS/WRITEDATA lines and stretches the losing and serviced requesters with BUSYWAIT until their transfer completes. It sits between both caches and the single main memory model, below the controlunit/cache layer.

## Interface
Parameters:
- ADDR_W, 6, block address width
- DATA_W, 32, block data width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- I_READ  in  1  instruction-cache read request, level, held until I_BUSYWAIT falls
- I_ADDRESS  in  ADDR_W  instruction block address
- I_READDATA  out  DATA_W  registered instruction block
- I_BUSYWAIT  out  1  instruction requester stall
- D_READ / D_WRITE  in  1 each  data-cache requests, level
- D_ADDRESS  in  ADDR_W  data block address
- D_WRITEDATA  in  DATA_W  data block to write
- D_READDATA  out  DATA_W  registered data block
- D_BUSYWAIT  out  1  data requester stall
- M_READ / M_WRITE  out  1 each  memory strobes, registered
- M_ADDRESS  out  ADDR_W  registered
- M_WRITEDATA  out  DATA_W  registered
- M_READDATA  in  DATA_W  memory read data
- M_BUSYWAIT  in  1  memory stall

## Operation
- States: IDLE, SERVE, RELEASE. Registers `grant` (I or D) and `last` (last served, reset I).
- IDLE:
  - If any request is high, select a winner. Register grant and M_* from the winner: M_READ = I_READ or (D_READ and not D_WRITE); M_WRITE = D_WRITE. Go to SERVE.
  - D_READ and D_WRITE both high is treated as a write.
- SERVE:
  - M_* hold their values. `served` counts SERVE cycles (saturating at 1).
  - At a posedge where `served`=1 and M_BUSYWAIT=0: capture M_READDATA into the grantee's READDATA on a read, clear M_READ/M_WRITE, set `last`=grant, go to RELEASE.
- RELEASE: lasts exactly one cycle, then IDLE. It is the turnaround cycle in which the requester drops its request.
- X_BUSYWAIT is combinational: (X request high) and not (state=RELEASE and grant=X). A non-granted requester stays stalled.
- Reset values: state IDLE; M_READ/M_WRITE 0; M_ADDRESS 0; M_WRITEDATA 0; I_READDATA/D_READDATA 0; last=I; served 0.
- Reset mid-transfer: all registers return to reset values immediately and the transfer is abandoned. Busywaits follow the requests.
- A request that drops during SERVE (illegal) still completes; the data is discarded.

## Timing
- Request seen at edge k in IDLE → M_* valid after edge k.
- Memory holds M_BUSYWAIT for N cycles → completion at edge k+N+1 → requester BUSYWAIT low after that edge. READDATA is valid in the same cycle.
- Back-to-back: the next grant is taken at the edge leaving RELEASE+IDLE, so there is a 2-cycle minimum gap between memory strobes.
- A single-cycle memory (M_BUSYWAIT never high) completes at edge k+1.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous I and D requests in IDLE, grant goes to the requester ≠ `last`.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, D always wins. `last` is still maintained but unused.

## Structure
- Package memory_arbiter_pkg holds:
  - state enum (IDLE, SERVE, RELEASE)
  - requester IDs REQ_I=0, REQ_D=1
  - default ADDR_W/DATA_W constants
- One sub-module, arb_pick: combinational winner selection from (i_req, d_req, last). The macro is confined to this sub-module.

## Test plan
- Only I_READ at address 6'h05; memory returns 32'hDEADBEEF after 5 busy cycles → M_READ high one cycle after request; I_READDATA=32'hDEADBEEF; I_BUSYWAIT falls exactly 6 edges after grant; D_BUSYWAIT stays 0.
- D_WRITE at 6'h3F with data 32'h12345678 → M_WRITE=1, M_ADDRESS=6'h3F, M_WRITEDATA=32'h12345678 until completion; D_READDATA unchanged.
- I and D request in the same cycle after reset:
  - with ARB_ROUND_ROBIN_EN: D served first (last=I), then I.
  - without: D served first; repeating the pair gives D,D.
- Continuous simultaneous requests with ARB_ROUND_ROBIN_EN → grants alternate D,I,D,I; each requester stalled while the other is served.
- RESET low during SERVE cycle 3 → M_READ=0 and state IDLE asynchronously. After release with the request still high, the transfer restarts from IDLE.
- D_READ and D_WRITE both high → M_WRITE=1, M_READ=0.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the I/D cache to main-memory arbiter: FSM states, requester IDs, default widths.
package memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational winner selection between I and D requests.
// ARB_ROUND_ROBIN_EN: tie goes to the requester not served last; otherwise D always wins a tie.
module arb_pick
  import memory_arbiter_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last,
  output logic    any,
  output req_id_t winner
);

  always_comb begin
    any    = i_req | d_req;
    winner = REQ_D;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last == REQ_I) ? REQ_D : REQ_I;
`else
      winner = REQ_D;
`endif
    end else if (i_req) begin
      winner = REQ_I;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; keep the port for a uniform interface.
  logic unused_last;
  assign unused_last = (last == REQ_D);
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Grants the single main-memory port to the I or D cache one transfer at a time (IDLE/SERVE/RELEASE).
// Tie-break policy comes from arb_pick (ARB_ROUND_ROBIN_EN selects round robin, else D priority).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);

  state_t  state;
  req_id_t grant;
  req_id_t last;
  logic    served;

  logic    i_req;
  logic    d_req;
  logic    pick_any;
  req_id_t pick_win;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last   (last),
    .any    (pick_any),
    .winner (pick_win)
  );

  // A requester is released only in the turnaround cycle of its own transfer.
  assign I_BUSYWAIT = i_req && !(state == RELEASE && grant == REQ_I);
  assign D_BUSYWAIT = d_req && !(state == RELEASE && grant == REQ_D);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      grant       <= REQ_I;
      last        <= REQ_I;
      served      <= 1'b0;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDRESS   <= '0;
      M_WRITEDATA <= '0;
      I_READDATA  <= '0;
      D_READDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant  <= pick_win;
            // The strobes go out on this edge, so the first SERVE cycle already counts.
            served <= 1'b1;
            state  <= SERVE;
            if (pick_win == REQ_D) begin
              M_READ      <= D_READ & ~D_WRITE;
              M_WRITE     <= D_WRITE;
              M_ADDRESS   <= D_ADDRESS;
              M_WRITEDATA <= D_WRITEDATA;
            end else begin
              M_READ      <= 1'b1;
              M_WRITE     <= 1'b0;
              M_ADDRESS   <= I_ADDRESS;
            end
          end
        end
        SERVE: begin
          if (served && !M_BUSYWAIT) begin
            // A requester that dropped mid-transfer gets no data.
            if (grant == REQ_I) begin
              if (M_READ && I_READ) I_READDATA <= M_READDATA;
            end else begin
              if (M_READ && D_READ) D_READDATA <= M_READDATA;
            end
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            last    <= grant;
            served  <= 1'b0;
            state   <= RELEASE;
          end else begin
            served <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed requests, a latency-programmable memory model, negedge monitor.
module tb_memory_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITEDATA = '0;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          M_READ;
  logic          M_WRITE;
  logic [AW-1:0] M_ADDRESS;
  logic [DW-1:0] M_WRITEDATA;
  logic [DW-1:0] M_READDATA = '0;
  logic          M_BUSYWAIT = 1'b0;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit            who;   // 0 = I, 1 = D
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } strb_t;

  typedef struct {
    bit            who;
    logic [DW-1:0] data;
  } done_t;

  strb_t strobe_q[$];
  done_t done_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=event want=none (cyc %0d)", nm, cyc);
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [64];
  int  mem_lat = 0;
  bit  mstarted = 0;
  int  mcnt = 0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[5] = 32'hDEADBEEF;
    forever begin
      @(posedge CLK);
      #1;
      if (M_READ || M_WRITE) begin
        if (!mstarted) begin
          mstarted   = 1;
          mcnt       = mem_lat;
          M_BUSYWAIT = (mcnt > 0);
          if (M_WRITE) mem[M_ADDRESS] = M_WRITEDATA;
          else         M_READDATA = mem[M_ADDRESS];
        end else if (mcnt > 0) begin
          mcnt--;
          M_BUSYWAIT = (mcnt > 0);
        end
      end else begin
        mstarted   = 0;
        M_BUSYWAIT = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int    n_strobe = 0;
  int    t_strobe = 0;
  int    t_done   = 0;
  bit    prev_st  = 0;
  bit    cur_vld  = 0;
  bit    ibw_hi   = 0;
  bit    dbw_hi   = 0;
  strb_t cur;
  done_t dn;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prev_st = 0;
        cur_vld = 0;
      end else begin
        if ((M_READ || M_WRITE) && !prev_st) begin
          if (strobe_q.size() == 0) fail("strobe_unexpected");
          else begin
            cur = strobe_q.pop_front();
            cur_vld = 1;
            n_strobe++;
            t_strobe = cyc;
            check("m_read", {31'b0, M_READ}, {31'b0, cur.rd});
            check("m_write", {31'b0, M_WRITE}, {31'b0, cur.wr});
          end
        end
        if ((M_READ || M_WRITE) && cur_vld) begin
          check("m_addr_hold", {26'b0, M_ADDRESS}, {26'b0, cur.addr});
          if (cur.wr) check("m_wdata_hold", M_WRITEDATA, cur.wd);
          if (I_READ) check("i_stall", {31'b0, I_BUSYWAIT}, 32'd1);
          if (D_READ || D_WRITE) check("d_stall", {31'b0, D_BUSYWAIT}, 32'd1);
        end
        if (I_READ && !I_BUSYWAIT) begin
          if (done_q.size() == 0) fail("i_done_unexpected");
          else begin
            dn = done_q.pop_front();
            t_done = cyc;
            check("done_who_i", {31'b0, dn.who}, 32'd0);
            check("i_readdata", I_READDATA, dn.data);
          end
        end
        if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
          if (done_q.size() == 0) fail("d_done_unexpected");
          else begin
            dn = done_q.pop_front();
            t_done = cyc;
            check("done_who_d", {31'b0, dn.who}, 32'd1);
            check("d_readdata", D_READDATA, dn.data);
          end
        end
        if (!I_READ && I_BUSYWAIT) ibw_hi = 1;
        if (!D_READ && !D_WRITE && D_BUSYWAIT) dbw_hi = 1;
        prev_st = M_READ || M_WRITE;
      end
    end
  end

  // ---------------- stimulus ----------------
  int i_left = 0;
  int d_left = 0;

  function automatic strb_t mk_s(bit who, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] wd);
    strb_t s;
    s.who = who; s.rd = rd; s.wr = wr; s.addr = a; s.wd = wd;
    return s;
  endfunction

  function automatic done_t mk_d(bit who, logic [DW-1:0] data);
    done_t d;
    d.who = who; d.data = data;
    return d;
  endfunction

  // Requesters hold their request until their quota of completions is reached.
  task automatic run_reqs(input int budget);
    int n = 0;
    while ((i_left > 0 || d_left > 0) && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
      if (I_READ && !I_BUSYWAIT) begin
        i_left--;
        if (i_left == 0) I_READ = 1'b0;
      end
      if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
        d_left--;
        if (d_left == 0) begin
          D_READ  = 1'b0;
          D_WRITE = 1'b0;
        end
      end
    end
    check("run_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #10;
    RESET = 1'b1;
  endtask

  int req_cyc, rel_cyc, s0, n;

  initial begin
    // reset values
    #12;
    check("rst_m_read", {31'b0, M_READ}, 32'd0);
    check("rst_m_write", {31'b0, M_WRITE}, 32'd0);
    check("rst_m_addr", {26'b0, M_ADDRESS}, 32'd0);
    check("rst_m_wdata", M_WRITEDATA, 32'd0);
    check("rst_i_rdata", I_READDATA, 32'd0);
    check("rst_d_rdata", D_READDATA, 32'd0);
    check("rst_i_bw", {31'b0, I_BUSYWAIT}, 32'd0);
    check("rst_d_bw", {31'b0, D_BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;

    // I read of 0x05, five busy cycles
    mem_lat = 5;
    strobe_q.push_back(mk_s(0, 1, 0, 6'h05, 32'h0));
    done_q.push_back(mk_d(0, 32'hDEADBEEF));
    @(posedge CLK);
    #2;
    I_ADDRESS = 6'h05; I_READ = 1'b1; i_left = 1; req_cyc = cyc;
    run_reqs(40);
    check("i_grant_lat", t_strobe - req_cyc, 32'd1);
    check("i_done_lat", t_done - t_strobe, 32'd6);
    check("d_bw_idle", {31'b0, dbw_hi}, 32'd0);

    // D write to 0x3F, single-cycle memory
    mem_lat = 0;
    strobe_q.push_back(mk_s(1, 0, 1, 6'h3F, 32'h12345678));
    done_q.push_back(mk_d(1, 32'h0));
    @(posedge CLK);
    #2;
    D_ADDRESS = 6'h3F; D_WRITEDATA = 32'h12345678; D_WRITE = 1'b1; d_left = 1;
    run_reqs(40);
    check("d_wr_done_lat", t_done - t_strobe, 32'd1);

    // D read back of 0x3F
    mem_lat = 1;
    strobe_q.push_back(mk_s(1, 1, 0, 6'h3F, 32'h0));
    done_q.push_back(mk_d(1, 32'h12345678));
    @(posedge CLK);
    #2;
    D_READ = 1'b1; d_left = 1;
    run_reqs(40);

    // simultaneous pair right after reset: D first, then I
    pulse_reset();
    mem_lat = 2;
    strobe_q.push_back(mk_s(1, 1, 0, 6'h21, 32'h0));
    done_q.push_back(mk_d(1, 32'hC0DE0021));
    strobe_q.push_back(mk_s(0, 1, 0, 6'h0A, 32'h0));
    done_q.push_back(mk_d(0, 32'hC0DE000A));
    @(posedge CLK);
    #2;
    I_ADDRESS = 6'h0A; D_ADDRESS = 6'h21;
    I_READ = 1'b1; D_READ = 1'b1; i_left = 1; d_left = 1;
    run_reqs(60);

    // continuous simultaneous requests, two each
    mem_lat = 2;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 2; k++) begin
      strobe_q.push_back(mk_s(1, 1, 0, 6'h22, 32'h0));
      done_q.push_back(mk_d(1, 32'hC0DE0022));
      strobe_q.push_back(mk_s(0, 1, 0, 6'h0B, 32'h0));
      done_q.push_back(mk_d(0, 32'hC0DE000B));
    end
`else
    for (int k = 0; k < 2; k++) begin
      strobe_q.push_back(mk_s(1, 1, 0, 6'h22, 32'h0));
      done_q.push_back(mk_d(1, 32'hC0DE0022));
    end
    for (int k = 0; k < 2; k++) begin
      strobe_q.push_back(mk_s(0, 1, 0, 6'h0B, 32'h0));
      done_q.push_back(mk_d(0, 32'hC0DE000B));
    end
`endif
    @(posedge CLK);
    #2;
    I_ADDRESS = 6'h0B; D_ADDRESS = 6'h22;
    I_READ = 1'b1; D_READ = 1'b1; i_left = 2; d_left = 2;
    run_reqs(100);

    // D_READ and D_WRITE together act as a write
    mem_lat = 1;
    strobe_q.push_back(mk_s(1, 0, 1, 6'h11, 32'hA5A5A5A5));
    done_q.push_back(mk_d(1, 32'hC0DE0022));
    @(posedge CLK);
    #2;
    D_ADDRESS = 6'h11; D_WRITEDATA = 32'hA5A5A5A5;
    D_READ = 1'b1; D_WRITE = 1'b1; d_left = 1;
    run_reqs(40);

    // reset in SERVE cycle 3, request held, transfer restarts
    mem_lat = 6;
    strobe_q.push_back(mk_s(0, 1, 0, 6'h0C, 32'h0));
    @(posedge CLK);
    #2;
    I_ADDRESS = 6'h0C; I_READ = 1'b1; i_left = 1;
    s0 = n_strobe; n = 0;
    while (n_strobe == s0 && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("abort_grant_timeout", (n >= 20) ? 32'd1 : 32'd0, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    check("abort_m_read", {31'b0, M_READ}, 32'd0);
    check("abort_m_addr", {26'b0, M_ADDRESS}, 32'd0);
    check("abort_i_rdata", I_READDATA, 32'd0);
    check("abort_d_rdata", D_READDATA, 32'd0);
    check("abort_i_bw", {31'b0, I_BUSYWAIT}, 32'd1);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    rel_cyc = cyc;
    strobe_q.push_back(mk_s(0, 1, 0, 6'h0C, 32'h0));
    done_q.push_back(mk_d(0, 32'hC0DE000C));
    run_reqs(60);
    check("restart_lat", t_strobe - rel_cyc, 32'd1);

    repeat (4) @(posedge CLK);
    #1;
    check("strobe_q_empty", strobe_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    check("i_bw_no_req", {31'b0, ibw_hi}, 32'd0);
    check("d_bw_no_req", {31'b0, dbw_hi}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
